// File: rtl/rf_writeback_ctrl.sv
// Register-file write port controller: zero-fills r0..r31 after reset, then merges
// single-cycle ALU writebacks (priority) with loads buffered in a small FIFO.
module rf_writeback_ctrl #(
  parameter int DEPTH          = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        busy,
  output logic [4:0]  WriteReg,
  output logic [1:0]  RegWrite,
  output logic [31:0] WriteData
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state_reg;
  logic [4:0]       fill_cnt_reg;
  logic [AW-1:0]    head_reg;
  logic [AW-1:0]    tail_reg;
  logic [AW:0]      count_reg;
  logic [DEPTH-1:0] q_kill_reg;
  logic [4:0]       q_dst_mem  [DEPTH];
  logic [31:0]      q_data_mem [DEPTH];

  logic run;
  logic alu_wr;
  logic push;
  logic pop;
  logic pop_wr;

  assign run       = (state_reg == RUN);
  assign busy      = !run;
  assign alu_ready = run;
  assign mem_ready = run && (count_reg < (AW+1)'(DEPTH));

  // r0 requests are accepted but fall through to the queue/idle branch.
  assign alu_wr = run && alu_valid && (alu_reg != 5'd0);
  assign push   = mem_valid && mem_ready;
  assign pop    = run && !alu_wr && (count_reg != '0);
  assign pop_wr = pop && !q_kill_reg[head_reg] && (q_dst_mem[head_reg] != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= CLEAR_ON_RESET ? INIT : RUN;
      fill_cnt_reg <= '0;
      RegWrite     <= 2'b00;
      WriteReg     <= '0;
      WriteData    <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
    end else if (state_reg == INIT) begin
      RegWrite     <= 2'b01;
      WriteReg     <= fill_cnt_reg;
      WriteData    <= '0;
      fill_cnt_reg <= fill_cnt_reg + 5'd1;
      if (fill_cnt_reg == 5'd31)
        state_reg <= RUN;
    end else begin
      if (alu_wr) begin
        RegWrite  <= 2'b01;
        WriteReg  <= alu_reg;
        WriteData <= alu_data;
      end else if (pop_wr) begin
        RegWrite  <= 2'b01;
        WriteReg  <= q_dst_mem[head_reg];
        WriteData <= q_data_mem[head_reg];
      end else begin
        RegWrite <= 2'b00;
      end
      if (push)
        tail_reg <= tail_reg + 1'b1;
      if (pop)
        head_reg <= head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_dst_mem[tail_reg]  <= mem_reg;
      q_data_mem[tail_reg] <= mem_data;
    end
  end

  // A load entering on the same edge as a matching ALU write is younger, so push wins.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_kill
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          q_kill_reg[gi] <= 1'b0;
        else if (push && (tail_reg == AW'(gi)))
          q_kill_reg[gi] <= 1'b0;
        else if (alu_wr && (q_dst_mem[gi] == alu_reg))
          q_kill_reg[gi] <= 1'b1;
      end
    end
  endgenerate

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed bench for rf_writeback_ctrl: a scoreboard of expected register-file writes
// plus a behavioural register file capturing the write port.
module tb_rf_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_reg, mem_reg;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, busy;
  logic [4:0]  WriteReg;
  logic [1:0]  RegWrite;
  logic [31:0] WriteData;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t         sb [$];
  wr_t         pending [$];
  wr_t         got;
  logic [31:0] rf [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  rf_writeback_ctrl #(.DEPTH(4), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .busy(busy), .WriteReg(WriteReg), .RegWrite(RegWrite), .WriteData(WriteData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_init();
    for (int i = 0; i < 32; i++) sb.push_back('{r: 5'(i), d: 32'h0});
  endtask

  // Behavioural register file: captures the port on the edge after presentation.
  always @(posedge clk)
    if (rst === 1'b0 && RegWrite === 2'b01)
      rf[WriteReg] <= WriteData;

  // Every presented write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b0 && RegWrite !== 2'b00) begin
      check("regwrite_code", {30'b0, RegWrite}, 32'h1);
      if (RegWrite === 2'b01) begin
        check("write_expected", {31'b0, sb.size() > 0}, 32'h1);
        if (sb.size() > 0) begin
          got = sb.pop_front();
          $display("write r%0d = %h (expected r%0d = %h)", WriteReg, WriteData, got.r, got.d);
          check("write_reg", {27'b0, WriteReg}, {27'b0, got.r});
          check("write_data", WriteData, got.d);
        end
      end
    end
  end

  initial begin
    int busy_cnt, ready_bad, loads_sent;
    bit fifth_acc;
    rst = 1'b1;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
    #3;
    check("rst_regwrite", {30'b0, RegWrite}, 32'h0);
    check("rst_writereg", {27'b0, WriteReg}, 32'h0);
    check("rst_writedata", WriteData, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h1);
    check("rst_alu_ready", {31'b0, alu_ready}, 32'h0);

    // Reset fill
    push_init();
    @(negedge clk);
    rst = 1'b0;
    #1;
    busy_cnt = 0; ready_bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy) busy_cnt++;
      if (busy && (alu_ready || mem_ready)) ready_bad++;
      if (c < 40) step();
    end
    check("fill_busy_cycles", busy_cnt, 32'd32);
    check("fill_ready_in_init", ready_bad, 32'd0);
    check("fill_all_written", sb.size(), 32'd0);
    check("fill_r5", rf[5], 32'h0);

    // ALU priority over a simultaneous load
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h11111111;
    mem_valid = 1'b1; mem_reg = 5'd4; mem_data = 32'hAAAAAAAA;
    sb.push_back('{r: 5'd3, d: 32'h11111111});
    sb.push_back('{r: 5'd4, d: 32'hAAAAAAAA});
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("prio_first_regwrite", {30'b0, RegWrite}, 32'h1);
    check("prio_first_reg", {27'b0, WriteReg}, 32'd3);
    step();
    check("prio_second_regwrite", {30'b0, RegWrite}, 32'h1);
    check("prio_second_reg", {27'b0, WriteReg}, 32'd4);
    step(); step();
    check("prio_r3", rf[3], 32'h11111111);
    check("prio_r4", rf[4], 32'hAAAAAAAA);

    // Queue full under continuous ALU traffic
    loads_sent = 0;
    alu_valid = 1'b1; alu_reg = 5'd7;
    for (int c = 0; c < 8; c++) begin
      alu_data = 32'h7000 + 32'(c);
      sb.push_back('{r: 5'd7, d: alu_data});
      mem_valid = 1'b1;
      mem_reg   = 5'(10 + loads_sent);
      mem_data  = 32'h100 + 32'(loads_sent);
      if (mem_ready) begin
        pending.push_back('{r: mem_reg, d: mem_data});
        loads_sent++;
      end
      step();
    end
    alu_valid = 1'b0;
    mem_reg   = 5'(10 + loads_sent);
    mem_data  = 32'h100 + 32'(loads_sent);
    check("full_accepts", loads_sent, 32'd4);
    check("full_mem_ready", {31'b0, mem_ready}, 32'h0);
    while (pending.size() > 0) sb.push_back(pending.pop_front());
    fifth_acc = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (mem_valid && mem_ready) begin
        sb.push_back('{r: mem_reg, d: mem_data});
        fifth_acc = 1'b1;
      end
      step();
      if (fifth_acc) mem_valid = 1'b0;
      if (k < 4) begin
        check("drain_regwrite", {30'b0, RegWrite}, 32'h1);
        check("drain_reg", {27'b0, WriteReg}, 32'(10 + k));
      end
    end
    mem_valid = 1'b0;
    check("fifth_accepted", {31'b0, fifth_acc}, 32'h1);
    step(); step();
    check("full_r7", rf[7], 32'h7007);
    check("full_r14", rf[14], 32'h104);

    // Write-after-write kill
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h77;
    mem_valid = 1'b1; mem_reg = 5'd9; mem_data = 32'hDEAD;
    sb.push_back('{r: 5'd7, d: 32'h77});
    step();
    mem_valid = 1'b0;
    alu_reg = 5'd9; alu_data = 32'hBEEF;
    sb.push_back('{r: 5'd9, d: 32'hBEEF});
    step();
    alu_valid = 1'b0;
    step();
    check("waw_killed_pop", {30'b0, RegWrite}, 32'h0);
    check("waw_queue_empty", {31'b0, mem_ready}, 32'h1);
    step();
    check("waw_r9", rf[9], 32'hBEEF);

    // Load pushed on the same edge as a matching ALU write survives
    alu_valid = 1'b1; alu_reg = 5'd12; alu_data = 32'h1;
    mem_valid = 1'b1; mem_reg = 5'd12; mem_data = 32'h2;
    sb.push_back('{r: 5'd12, d: 32'h1});
    sb.push_back('{r: 5'd12, d: 32'h2});
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    step(); step();
    check("same_edge_r12", rf[12], 32'h2);

    // r0 suppression
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFFFFFF;
    mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'h1234;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("r0_idle", {30'b0, RegWrite}, 32'h0);
      step();
    end
    check("r0_value", rf[0], 32'h0);

    // Mid-run reset with loads queued behind ALU traffic
    for (int j = 0; j < 3; j++) begin
      alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h700 + 32'(j);
      mem_valid = 1'b1; mem_reg = 5'(20 + j); mem_data = 32'hC0DE0000 + 32'(j);
      sb.push_back('{r: 5'd7, d: alu_data});
      step();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("midrst_presented", {30'b0, RegWrite}, 32'h1);
    check("midrst_three_queued", {31'b0, mem_ready}, 32'h1);
    void'(sb.pop_back());
    #2 rst = 1'b1;
    #1;
    check("midrst_regwrite", {30'b0, RegWrite}, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h1);
    sb.delete();
    push_init();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    for (int c = 0; c < 40; c++) step();
    check("midrst_fill_done", sb.size(), 32'd0);
    check("midrst_r20", rf[20], 32'h0);
    check("midrst_r7", rf[7], 32'h0);
    check("midrst_ready", {31'b0, mem_ready}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
